wb_shared_bus_arbiter: RTL and testbench
========================================

# wb_shared_bus_arbiter

Parametrised Wishbone B4 shared-bus interconnect: NM masters arbitrate for one shared bus that is address-decoded onto NS slaves. It supersedes the fixed two-master controller. Additions are a registered cycle-locked grant, runtime round-robin/fixed-priority selection, per-slave select decode, an unmapped-address error and a watchdog timeout error. It sits between the CPU/DMA masters and the peripheral slaves of the SoC bus.

## Interface
- DW, 32, data width; multiple of 8
- AW, 32, address width
- NM, 4, master count (2..8)
- NS, 4, slave count (1..16)
- MATCH_ADDR, 0, NS*AW packed; slave s base in bits [s*AW +: AW]
- MATCH_MASK, 0, NS*AW packed; slave s hit when (adr & mask) == (match & mask)
- TIMEOUT, 255, cycles of unanswered strobe before a bus error; 0 disables the watchdog
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- roundORpriority  in  1  arbitration mode: 0 round-robin, 1 fixed priority (lowest index wins)
- i_adr / i_dat  in  NM*AW / NM*DW  master address / write data, master m at [m*W +: W]
- i_we, i_stb, i_cyc  in  NM each  master controls
- i_sel / i_cti / i_bte  in  NM*DW/8 / NM*3 / NM*2  master byte select / cycle type / burst type
- o_ack, o_err, o_rty  out  NM each  per-master termination
- m_dat_o  out  NM*DW  per-master read data
- o_gnt  out  NM  registered one-hot grant (status)
- o_adr, o_dat, o_we, o_sel, o_cti, o_bte  out  AW, DW, 1, DW/8, 3, 2  shared slave bus
- o_cyc, o_stb  out  NS each  per-slave cycle / strobe
- i_ack, i_err, i_rty  in  NS each  slave terminations
- s_dat_i  in  NS*DW  slave read data, slave s at [s*DW +: DW]

## Operation
- FSM states: IDLE, OWNED.
- IDLE to OWNED: taken at the next edge when any i_cyc is high. That edge loads the winner into the one-hot grant register.
- Round-robin arbitration: search starts at the last grantee + 1, modulo NM.
- Fixed-priority arbitration: the lowest index with i_cyc high wins.
- roundORpriority is sampled only in IDLE.
- OWNED: grant held while the granted master's i_cyc is high. i_cyc of other masters is ignored.
- OWNED to IDLE: taken at the edge after the granted i_cyc falls. The grant clears. The round-robin pointer updates to the released master.
- Decode: combinational from the granted i_adr. The selected slave is the lowest index s that hits.
- o_cyc[s]: driven with the granted master's i_cyc, for the selected slave only.
- o_stb[s]: driven with the granted master's i_stb, for the selected slave only. All other slaves see 0 on both.
- Shared-bus muxing: adr, dat, we, sel, cti and bte come from the granted master.
- Return-path muxing: ack, err, rty and dat go to the granted master only. Non-granted masters see terminations 0 and m_dat_o 0.
- Unmapped address: no slave hits while the granted stb is high. o_err to the granted master = 1 in the same cycle; no slave strobe is raised.
- Watchdog: counter increments each cycle the granted stb is high and the selected slave gives no ack/err/rty. The counter clears on any termination or when stb is low.
- Watchdog expiry: on reaching TIMEOUT, o_err = 1 for exactly one cycle to the granted master, and the counter clears. The slave strobe stays asserted.
- Termination priority (when several are asserted at once): err over rty over ack. Only the highest is forwarded.
- Unused outputs drive 0, never z.

## Timing
- Reset values:
  - state IDLE, o_gnt 0, round-robin pointer NM-1 (master 0 first)
  - watchdog counter 0
  - every output 0
- Arbitration latency: 1 cycle from i_cyc rising to o_gnt/o_cyc asserting.
- Data path: zero-latency combinational pass-through once granted. A slave ack in cycle k reaches the master in cycle k.
- Handover: after the owner drops cyc, there is at least one IDLE cycle before the next grant.
- Reset mid-transfer: o_gnt and all outputs are 0 from the edge that samples i_rst, regardless of slave activity.
- Simultaneous requests in IDLE: exactly one grant, resolved by mode. A grant never changes while the owner holds cyc, including during bursts (cti 010).
- Width rule: the watchdog counter is clog2(TIMEOUT+1) bits and saturates-free because it clears on expiry.

## Test plan
- Single master, slave hit: reset; m1 cyc/stb, adr 0x2000_0010 with slave 1 = 0x2000_0000/0xF000_0000.
  - o_gnt = 0010 after 1 cycle; o_stb = 0010.
  - Slave ack returns on o_ack[1] in the same cycle.
  - m_dat_o[1] = s_dat_i[1], e.g. 0xDEADBEEF.
- Round-robin with all 4 masters requesting continuously, each releasing after one ack:
  - Grant order 0,1,2,3,0.
  - With roundORpriority = 1, the grant order is 0,0,0.
- Lock during burst: m2 owns a 4-beat cti = 010 burst while m0 requests. o_gnt stays 0100 for all beats; m0 is granted 2 cycles after m2 drops cyc.
- Unmapped address 0xF000_0000: o_err[m] = 1 the same cycle; all o_stb = 0.
- Watchdog with TIMEOUT = 8 and a silent slave: o_err pulses once after 8 stb cycles, then repeats every 8 cycles until the master drops cyc.
- Reset mid-burst: assert i_rst during beat 2. At the next edge all outputs are 0 and o_gnt = 0; after deassert, master 0 is granted first.

Source files
------------

// File: rtl/wb_shared_bus_arbiter.sv
// wb_shared_bus_arbiter: NM-master / NS-slave Wishbone B4 shared bus with a
// cycle-locked grant, address decode, unmapped-address and watchdog errors.
module wb_shared_bus_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int NM = 4,
    parameter int NS = 4,
    parameter logic [NS*AW-1:0] MATCH_ADDR = '0,
    parameter logic [NS*AW-1:0] MATCH_MASK = '0,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 roundORpriority,
    input  logic [NM*AW-1:0]     i_adr,
    input  logic [NM*DW-1:0]     i_dat,
    input  logic [NM-1:0]        i_we,
    input  logic [NM-1:0]        i_stb,
    input  logic [NM-1:0]        i_cyc,
    input  logic [NM*DW/8-1:0]   i_sel,
    input  logic [NM*3-1:0]      i_cti,
    input  logic [NM*2-1:0]      i_bte,
    output logic [NM-1:0]        o_ack,
    output logic [NM-1:0]        o_err,
    output logic [NM-1:0]        o_rty,
    output logic [NM*DW-1:0]     m_dat_o,
    output logic [NM-1:0]        o_gnt,
    output logic [AW-1:0]        o_adr,
    output logic [DW-1:0]        o_dat,
    output logic                 o_we,
    output logic [DW/8-1:0]      o_sel,
    output logic [2:0]           o_cti,
    output logic [1:0]           o_bte,
    output logic [NS-1:0]        o_cyc,
    output logic [NS-1:0]        o_stb,
    input  logic [NS-1:0]        i_ack,
    input  logic [NS-1:0]        i_err,
    input  logic [NS-1:0]        i_rty,
    input  logic [NS*DW-1:0]     s_dat_i
);
    localparam int PW   = (NM > 1) ? $clog2(NM) : 1;
    localparam int SELW = DW / 8;
    localparam int WDW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST =
        WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t          r_state;
    logic [NM-1:0]   r_gnt;
    logic [PW-1:0]   r_ptr;
    logic [WDW-1:0]  r_wd;

    logic [PW-1:0]   w_win;
    int              w_best;
    int              w_dist;
    logic [PW-1:0]   w_gidx;
    logic            w_gcyc, w_gstb, w_gwe;
    logic [AW-1:0]   w_gadr;
    logic [DW-1:0]   w_gdat;
    logic [SELW-1:0] w_gsel;
    logic [2:0]      w_gcti;
    logic [1:0]      w_gbte;
    logic            w_hit;
    logic [NS-1:0]   w_ssel;
    logic            w_s_ack, w_s_err, w_s_rty;
    logic [DW-1:0]   w_sdat;
    logic            w_wd_run, w_wd_exp;
    logic            w_err, w_rty, w_ack;

    // Distance from the search start; smallest distance with cyc high wins.
    always_comb begin
        w_win  = '0;
        w_best = NM;
        w_dist = 0;
        for (int m = 0; m < NM; m++) begin
            w_dist = roundORpriority ? m
                   : (m + NM - 1 - int'(r_ptr)) % NM;
            if (i_cyc[m] && w_dist < w_best) begin
                w_best = w_dist;
                w_win  = PW'(m);
            end
        end
    end

    always_comb begin
        w_gidx = '0;
        w_gcyc = 1'b0;
        w_gstb = 1'b0;
        w_gwe  = 1'b0;
        w_gadr = '0;
        w_gdat = '0;
        w_gsel = '0;
        w_gcti = '0;
        w_gbte = '0;
        for (int m = 0; m < NM; m++) begin
            if (r_gnt[m]) begin
                w_gidx = PW'(m);
                w_gcyc = i_cyc[m];
                w_gstb = i_stb[m];
                w_gwe  = i_we[m];
                w_gadr = i_adr[m*AW +: AW];
                w_gdat = i_dat[m*DW +: DW];
                w_gsel = i_sel[m*SELW +: SELW];
                w_gcti = i_cti[m*3 +: 3];
                w_gbte = i_bte[m*2 +: 2];
            end
        end
    end

    // Scan downward so the lowest matching slave is the one kept.
    always_comb begin
        w_hit   = 1'b0;
        w_ssel  = '0;
        w_s_ack = 1'b0;
        w_s_err = 1'b0;
        w_s_rty = 1'b0;
        w_sdat  = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if ((w_gadr & MATCH_MASK[s*AW +: AW]) ==
                (MATCH_ADDR[s*AW +: AW] & MATCH_MASK[s*AW +: AW])) begin
                w_hit     = |r_gnt;
                w_ssel    = '0;
                w_ssel[s] = |r_gnt;
                w_s_ack   = i_ack[s];
                w_s_err   = i_err[s];
                w_s_rty   = i_rty[s];
                w_sdat    = s_dat_i[s*DW +: DW];
            end
        end
    end

    assign w_wd_run = (TIMEOUT != 0) & w_gcyc & w_gstb & w_hit
                    & ~(w_s_ack | w_s_err | w_s_rty);
    assign w_wd_exp = w_wd_run & (r_wd == WD_LAST);

    assign w_err = w_gstb & (~w_hit | w_s_err | w_wd_exp);
    assign w_rty = w_gstb & w_hit & w_s_rty & ~w_s_err;
    assign w_ack = w_gstb & w_hit & w_s_ack & ~w_s_err & ~w_s_rty;

    assign o_ack = r_gnt & {NM{w_ack}};
    assign o_err = r_gnt & {NM{w_err}};
    assign o_rty = r_gnt & {NM{w_rty}};
    assign o_gnt = r_gnt;

    assign o_cyc = w_ssel & {NS{w_gcyc}};
    assign o_stb = w_ssel & {NS{w_gstb}};
    assign o_adr = w_gadr;
    assign o_dat = w_gdat;
    assign o_we  = w_gwe;
    assign o_sel = w_gsel;
    assign o_cti = w_gcti;
    assign o_bte = w_gbte;

    always_comb begin
        m_dat_o = '0;
        for (int m = 0; m < NM; m++) begin
            if (r_gnt[m]) m_dat_o[m*DW +: DW] = w_sdat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ptr   <= PW'(NM - 1);
            r_wd    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_wd <= '0;
                    if (|i_cyc) begin
                        r_gnt   <= NM'(1) << w_win;
                        r_state <= S_OWNED;
                    end
                end
                S_OWNED: begin
                    if (!w_gcyc) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_gidx;
                        r_wd    <= '0;
                        r_state <= S_IDLE;
                    end else if (w_wd_run) begin
                        r_wd <= w_wd_exp ? '0 : r_wd + WDW'(1);
                    end else begin
                        r_wd <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
// tb_wb_shared_bus_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level ownership model of the shared bus.
`timescale 1ns/1ps
module tb_wb_shared_bus_arbiter;
    localparam int DW = 32, AW = 32, NM = 4, NS = 4, TO = 8;
    localparam int SELW = DW / 8;
    localparam int BW = AW + DW + 1 + SELW + 3 + 2;
    localparam logic [NS*AW-1:0] MADR = {32'h4000_0000, 32'h3000_0000,
                                         32'h2000_0000, 32'h1000_0000};
    localparam logic [NS*AW-1:0] MMSK = {4{32'hF000_0000}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   m_adr [NM];
    logic [DW-1:0]   m_dat [NM];
    logic            m_we  [NM];
    logic            m_stb [NM];
    logic            m_cyc [NM];
    logic [SELW-1:0] m_sel [NM];
    logic [2:0]      m_cti [NM];
    logic [1:0]      m_bte [NM];
    logic            s_ack [NS];
    logic            s_err [NS];
    logic            s_rty [NS];
    logic [DW-1:0]   s_dat [NS];

    logic [NM*AW-1:0]   i_adr;
    logic [NM*DW-1:0]   i_dat;
    logic [NM-1:0]      i_we, i_stb, i_cyc;
    logic [NM*SELW-1:0] i_sel;
    logic [NM*3-1:0]    i_cti;
    logic [NM*2-1:0]    i_bte;
    logic [NS-1:0]      i_ack, i_err, i_rty;
    logic [NS*DW-1:0]   s_dat_i;

    logic [NM-1:0]    o_ack, o_err, o_rty, o_gnt;
    logic [NM*DW-1:0] m_dat_o;
    logic [AW-1:0]    o_adr;
    logic [DW-1:0]    o_dat;
    logic             o_we;
    logic [SELW-1:0]  o_sel;
    logic [2:0]       o_cti;
    logic [1:0]       o_bte;
    logic [NS-1:0]    o_cyc, o_stb;

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign i_adr[g*AW +: AW]     = m_adr[g];
        assign i_dat[g*DW +: DW]     = m_dat[g];
        assign i_we[g]               = m_we[g];
        assign i_stb[g]              = m_stb[g];
        assign i_cyc[g]              = m_cyc[g];
        assign i_sel[g*SELW +: SELW] = m_sel[g];
        assign i_cti[g*3 +: 3]       = m_cti[g];
        assign i_bte[g*2 +: 2]       = m_bte[g];
    end
    for (genvar g = 0; g < NS; g++) begin : g_s
        assign i_ack[g]            = s_ack[g];
        assign i_err[g]            = s_err[g];
        assign i_rty[g]            = s_rty[g];
        assign s_dat_i[g*DW +: DW] = s_dat[g];
    end

    wb_shared_bus_arbiter #(
        .DW(DW), .AW(AW), .NM(NM), .NS(NS),
        .MATCH_ADDR(MADR), .MATCH_MASK(MMSK), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .roundORpriority(mode),
        .i_adr(i_adr), .i_dat(i_dat), .i_we(i_we),
        .i_stb(i_stb), .i_cyc(i_cyc), .i_sel(i_sel),
        .i_cti(i_cti), .i_bte(i_bte),
        .o_ack(o_ack), .o_err(o_err), .o_rty(o_rty),
        .m_dat_o(m_dat_o), .o_gnt(o_gnt),
        .o_adr(o_adr), .o_dat(o_dat), .o_we(o_we),
        .o_sel(o_sel), .o_cti(o_cti), .o_bte(o_bte),
        .o_cyc(o_cyc), .o_stb(o_stb),
        .i_ack(i_ack), .i_err(i_err), .i_rty(i_rty),
        .s_dat_i(s_dat_i)
    );

    int errors = 0;
    int checks = 0;

    // Model: who owns the bus, who last released it, silent-strobe run.
    int owner = -1;
    int last  = NM - 1;
    int wd    = 0;

    logic [NM-1:0]    exp_gnt, exp_ack, exp_err, exp_rty;
    logic [NS-1:0]    exp_scyc, exp_sstb;
    logic [BW-1:0]    exp_bus;
    logic [NM*DW-1:0] exp_rdat;

    // Slave s owns the 256 MB region starting at (s+1) << 28.
    function automatic int decode(input logic [AW-1:0] a);
        for (int s = 0; s < NS; s++) begin
            if (a[31:28] == 4'(s + 1)) return s;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int j;
        int s;
        if (rst) begin
            owner = -1; last = NM - 1; wd = 0;
        end else if (owner < 0) begin
            wd = 0;
            for (int k = 1; k <= NM; k++) begin
                j = mode ? k - 1 : (last + k) % NM;
                if (owner < 0 && m_cyc[j]) owner = j;
            end
        end else if (!m_cyc[owner]) begin
            last = owner; owner = -1; wd = 0;
        end else begin
            s = decode(m_adr[owner]);
            if (m_stb[owner] && s >= 0 &&
                !(s_ack[s] || s_err[s] || s_rty[s])) begin
                wd++;
                if (wd == TO) wd = 0;
            end else begin
                wd = 0;
            end
        end
    endtask

    task automatic model_outputs();
        int s;
        exp_gnt = '0; exp_ack = '0; exp_err = '0; exp_rty = '0;
        exp_scyc = '0; exp_sstb = '0; exp_bus = '0; exp_rdat = '0;
        if (owner >= 0) begin
            s = decode(m_adr[owner]);
            exp_gnt[owner] = 1'b1;
            exp_bus = {m_adr[owner], m_dat[owner], m_we[owner],
                       m_sel[owner], m_cti[owner], m_bte[owner]};
            if (s >= 0) begin
                exp_scyc[s] = m_cyc[owner];
                exp_sstb[s] = m_stb[owner];
                exp_rdat[owner*DW +: DW] = s_dat[s];
            end
            if (m_stb[owner]) begin
                if (s < 0) exp_err[owner] = 1'b1;
                else if (s_err[s]) exp_err[owner] = 1'b1;
                else if (s_rty[s]) exp_rty[owner] = 1'b1;
                else if (s_ack[s]) exp_ack[owner] = 1'b1;
                else if (m_cyc[owner] && wd + 1 == TO)
                    exp_err[owner] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        for (int m = 0; m < NM; m++) begin
            m_adr[m] = '0; m_dat[m] = '0; m_we[m] = 1'b0;
            m_stb[m] = 1'b0; m_cyc[m] = 1'b0; m_sel[m] = '0;
            m_cti[m] = '0; m_bte[m] = '0;
        end
        for (int s = 0; s < NS; s++) begin
            s_ack[s] = 1'b0; s_err[s] = 1'b0;
            s_rty[s] = 1'b0; s_dat[s] = '0;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int m = 0; m < NM; m++) begin
            m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
            m_adr[m] = 32'h1000_0000;
        end
        s_ack[0] = 1'b1;
        s_dat[0] = 32'h1234_5678;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (o_gnt !== '0)
            $display("FAIL reset_gnt: got %h expected 0", o_gnt);
        checks++;
        if ({o_cyc, o_stb} !== '0)
            $display("FAIL reset_slave: got %h expected 0", {o_cyc, o_stb});
        checks++;
        if ({o_ack, o_err, o_rty} !== '0)
            $display("FAIL reset_term: got %h expected 0",
                     {o_ack, o_err, o_rty});
        checks++;
        if ({o_adr, o_dat, o_we, o_sel, o_cti, o_bte} !== '0)
            $display("FAIL reset_bus: got %h expected 0", o_adr);
        checks++;
        if (m_dat_o !== '0)
            $display("FAIL reset_rdata: got %h expected 0", m_dat_o);
        errors += ((o_gnt !== '0) ? 1 : 0)
                + (({o_cyc, o_stb} !== '0) ? 1 : 0)
                + (({o_ack, o_err, o_rty} !== '0) ? 1 : 0)
                + (({o_adr, o_dat, o_we, o_sel, o_cti, o_bte} !== '0) ? 1 : 0)
                + ((m_dat_o !== '0) ? 1 : 0);
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_hit();
        clear_inputs();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        m_adr[1] = 32'h2000_0010;
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_latency: got %b expected 0000", o_gnt);
        end
        tick();
        s_ack[1] = 1'b1;
        s_dat[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (o_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL single_gnt: got %b expected 0010", o_gnt);
        end
        checks++;
        if (o_stb !== 4'b0010) begin
            errors++;
            $display("FAIL single_stb: got %b expected 0010", o_stb);
        end
        checks++;
        if (o_ack !== 4'b0010) begin
            errors++;
            $display("FAIL single_ack: got %b expected 0010", o_ack);
        end
        checks++;
        if (m_dat_o !== {64'h0, 32'hDEAD_BEEF, 32'h0}) begin
            errors++;
            $display("FAIL single_rdata: got %h expected %h", m_dat_o,
                     {64'h0, 32'hDEAD_BEEF, 32'h0});
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_arbitration(input logic pm);
        int want;
        int n;
        clear_inputs();
        mode = pm;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int m = 0; m < NM; m++) begin
            m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
            m_adr[m] = 32'h1000_0000 | 32'(m * 4);
        end
        s_ack[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            want = pm ? 0 : i % NM;
            n = 0;
            while (o_gnt === '0 && n < 4) begin
                tick();
                n++;
            end
            @(negedge clk);
            checks++;
            if (o_gnt !== (4'b0001 << want)) begin
                errors++;
                $display("FAIL arb_order mode=%0d step=%0d: got %b expected %b",
                         pm, i, o_gnt, 4'b0001 << want);
            end
            checks++;
            if (o_ack !== (4'b0001 << want)) begin
                errors++;
                $display("FAIL arb_ack mode=%0d step=%0d: got %b expected %b",
                         pm, i, o_ack, 4'b0001 << want);
            end
            m_cyc[want] = 1'b0; m_stb[want] = 1'b0;
            tick();
            checks++;
            if (o_gnt !== '0) begin
                errors++;
                $display("FAIL handover_idle step=%0d: got %b expected 0000",
                         i, o_gnt);
            end
            m_cyc[want] = 1'b1; m_stb[want] = 1'b1;
        end
        clear_inputs();
        tick(); tick();
        mode = 1'b0;
    endtask

    task automatic test_burst_lock();
        logic [AW-1:0] a;
        clear_inputs();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        m_adr[2] = 32'h3000_0000; m_cti[2] = 3'b010;
        tick();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        m_adr[0] = 32'h1000_0000;
        s_ack[2] = 1'b1;
        s_dat[2] = 32'h0BAD_CAFE;
        for (int b = 0; b < 4; b++) begin
            a = 32'h3000_0000 + 32'(b * 4);
            m_adr[2] = a;
            m_cti[2] = (b == 3) ? 3'b111 : 3'b010;
            @(negedge clk);
            checks++;
            if (o_gnt !== 4'b0100) begin
                errors++;
                $display("FAIL burst_gnt beat=%0d: got %b expected 0100",
                         b, o_gnt);
            end
            checks++;
            if (o_adr !== a || o_ack !== 4'b0100) begin
                errors++;
                $display("FAIL burst_beat beat=%0d: got adr=%h ack=%b expected adr=%h ack=0100",
                         b, o_adr, o_ack, a);
            end
            tick();
        end
        m_cyc[2] = 1'b0; m_stb[2] = 1'b0; s_ack[2] = 1'b0;
        tick();
        checks++;
        if (o_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL burst_release: got %b expected 0000", o_gnt);
        end
        tick();
        checks++;
        if (o_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL burst_next: got %b expected 0001", o_gnt);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_unmapped();
        clear_inputs();
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        m_adr[3] = 32'hF000_0000;
        for (int s = 0; s < NS; s++) s_ack[s] = 1'b1;
        @(negedge clk);
        checks++;
        if (o_err !== 4'b0000) begin
            errors++;
            $display("FAIL unmapped_idle: got %b expected 0000", o_err);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_err !== 4'b1000 || o_ack !== 4'b0000) begin
            errors++;
            $display("FAIL unmapped_err: got err=%b ack=%b expected err=1000 ack=0000",
                     o_err, o_ack);
        end
        checks++;
        if ({o_cyc, o_stb} !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_stb: got %h expected 00", {o_cyc, o_stb});
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_watchdog();
        logic want;
        clear_inputs();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        m_adr[1] = 32'h2000_0000;
        tick();
        for (int c = 1; c <= 26; c++) begin
            want = (c % TO == 0);
            @(negedge clk);
            checks++;
            if (o_err !== {2'b00, want, 1'b0}) begin
                errors++;
                $display("FAIL wd_err cycle=%0d: got %b expected %b",
                         c, o_err, {2'b00, want, 1'b0});
            end
            if (c == TO) begin
                checks++;
                if (o_stb !== 4'b0010) begin
                    errors++;
                    $display("FAIL wd_stb_held: got %b expected 0010", o_stb);
                end
            end
            tick();
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_midburst();
        clear_inputs();
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        m_adr[2] = 32'h3000_0000; m_cti[2] = 3'b010;
        s_ack[2] = 1'b1;
        s_dat[2] = 32'hA5A5_5A5A;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ack !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_beat2: got %b expected 0100", o_ack);
        end
        tick();
        checks++;
        if (o_gnt !== '0 || {o_cyc, o_stb} !== '0 ||
            {o_ack, o_err, o_rty} !== '0) begin
            errors++;
            $display("FAIL rstmid_ctl: got gnt=%b cyc=%b stb=%b ack=%b expected all 0",
                     o_gnt, o_cyc, o_stb, o_ack);
        end
        checks++;
        if (m_dat_o !== '0 || o_adr !== '0 || o_cti !== '0) begin
            errors++;
            $display("FAIL rstmid_data: got rdata=%h adr=%h expected 0",
                     m_dat_o, o_adr);
        end
        rst = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        m_adr[0] = 32'h1000_0000;
        tick();
        checks++;
        if (o_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_first: got %b expected 0001", o_gnt);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_random();
        int r;
        logic [3:0] nib;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(7) == 0) m_cyc[m] = ~m_cyc[m];
                m_stb[m] = m_cyc[m] && ($urandom_range(7) != 0);
                r = $urandom_range(8);
                nib = (r < 8) ? 4'(r % 4 + 1) : 4'h9;
                m_adr[m] = {nib, 28'($urandom)};
                m_dat[m] = $urandom;
                m_we[m]  = 1'($urandom);
                m_sel[m] = 4'($urandom);
                m_cti[m] = 3'($urandom);
                m_bte[m] = 2'($urandom);
            end
            for (int s = 0; s < NS; s++) begin
                s_ack[s] = ($urandom_range(9) == 0);
                s_err[s] = ($urandom_range(29) == 0);
                s_rty[s] = ($urandom_range(29) == 0);
                s_dat[s] = $urandom;
            end
            if ($urandom_range(31) == 0) mode = ~mode;
            @(negedge clk);
            model_outputs();
            checks++;
            if ({o_gnt, o_cyc, o_stb, o_ack, o_err, o_rty} !==
                {exp_gnt, exp_scyc, exp_sstb, exp_ack, exp_err, exp_rty}) begin
                errors++;
                $display("FAIL rnd_ctl cycle=%0d: got %h expected %h", c,
                         {o_gnt, o_cyc, o_stb, o_ack, o_err, o_rty},
                         {exp_gnt, exp_scyc, exp_sstb, exp_ack, exp_err, exp_rty});
            end
            checks++;
            if ({o_adr, o_dat, o_we, o_sel, o_cti, o_bte} !== exp_bus) begin
                errors++;
                $display("FAIL rnd_bus cycle=%0d: got %h expected %h", c,
                         {o_adr, o_dat, o_we, o_sel, o_cti, o_bte}, exp_bus);
            end
            checks++;
            if (m_dat_o !== exp_rdat) begin
                errors++;
                $display("FAIL rnd_rdata cycle=%0d: got %h expected %h",
                         c, m_dat_o, exp_rdat);
            end
            tick();
        end
        clear_inputs();
        mode = 1'b0;
        tick(); tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_hit();
        test_arbitration(1'b0);
        test_arbitration(1'b1);
        test_burst_lock();
        test_unmapped();
        test_watchdog();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time bound expired");
    end
endmodule
